// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the shift arbiter slice.
//   OP_SLL / OP_SRA : shift opcode encodings carried on reqN_op
//   DATA_WIDTH      : operand/result width (only 32 supported)
//   SHAMT_WIDTH     : shift-amount width, log2(DATA_WIDTH)
//   REQ0 / REQ1     : requester indices used for grant and resp_id
package shift_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned SHAMT_WIDTH = 5;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/shift_arbiter_if.sv
// Bundle of the two requester handshakes and the result handshake.
//   reqN_valid/op/data/shamt : requester N -> arbiter
//   reqN_ready               : arbiter -> requester N
//   resp_valid/id/data       : arbiter -> consumer
//   resp_ready               : consumer -> arbiter
// modport master : the requesters/consumer side
// modport slave  : the arbiter side
interface shift_arbiter_if;
  import shift_pkg::*;

  logic                   req0_valid;
  logic                   req0_ready;
  logic                   req0_op;
  logic [DATA_WIDTH-1:0]  req0_data;
  logic [SHAMT_WIDTH-1:0] req0_shamt;

  logic                   req1_valid;
  logic                   req1_ready;
  logic                   req1_op;
  logic [DATA_WIDTH-1:0]  req1_data;
  logic [SHAMT_WIDTH-1:0] req1_shamt;

  logic                   resp_valid;
  logic                   resp_ready;
  logic                   resp_id;
  logic [DATA_WIDTH-1:0]  resp_data;

  modport master (
    output req0_valid, req0_op, req0_data, req0_shamt,
    output req1_valid, req1_op, req1_data, req1_shamt,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_data, req0_shamt,
    input  req1_valid, req1_op, req1_data, req1_shamt,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data
  );

endinterface

// File: rtl/shift_arbiter_core.sv
// Purely combinational shifter: SLL (zero fill) or SRA (sign fill).
//   op_i    : OP_SLL / OP_SRA
//   data_i  : operand
//   shamt_i : shift amount
//   result_o: shifted operand
// Built as a log shifter, one stage per shamt bit (1/2/4/8/16).
module shift_core
  import shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = shift_pkg::DATA_WIDTH,
  parameter int unsigned SHAMT_WIDTH = shift_pkg::SHAMT_WIDTH
) (
  input  logic                   op_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic [DATA_WIDTH-1:0]  result_o
);

  logic [DATA_WIDTH-1:0] stage [SHAMT_WIDTH+1];
  logic                  fill;

  assign fill     = (op_i == OP_SRA) ? data_i[DATA_WIDTH-1] : 1'b0;
  assign stage[0] = data_i;

  for (genvar k = 0; k < SHAMT_WIDTH; k++) begin : g_stage
    localparam int unsigned S = 1 << k;
    always_comb begin
      stage[k+1] = stage[k];
      if (shamt_i[k]) begin
        if (op_i == OP_SRA) begin
          stage[k+1] = {{S{fill}}, stage[k][DATA_WIDTH-1:S]};
        end else begin
          stage[k+1] = {stage[k][DATA_WIDTH-1-S:0], {S{1'b0}}};
        end
      end
    end
  end

  assign result_o = stage[SHAMT_WIDTH];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between two requesters,
// with a one-entry registered result slot.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of shift_arbiter_if (two request handshakes in,
//           one result handshake out)
// The slot may reload in the same cycle it is consumed, giving one
// result per cycle under continuous consumption.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = shift_pkg::DATA_WIDTH,
  parameter int unsigned SHAMT_WIDTH = shift_pkg::SHAMT_WIDTH
) (
  input  logic           clock,
  input  logic           reset,
  shift_arbiter_if.slave bus
);

  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_id_q,    resp_id_d;
  logic [DATA_WIDTH-1:0]  resp_data_q,  resp_data_d;
  logic                   last_grant_q, last_grant_d;

  logic                   slot_free;
  logic                   sel_valid;
  logic                   sel_id;
  logic                   handshake;

  logic                   mux_op;
  logic [DATA_WIDTH-1:0]  mux_data;
  logic [SHAMT_WIDTH-1:0] mux_shamt;
  logic [DATA_WIDTH-1:0]  shift_result;

  assign slot_free = !resp_valid_q || bus.resp_ready;

  // Selection is independent of slot_free so priority only rotates
  // on an actual handshake, never while the slot is blocked.
  always_comb begin
    sel_valid = bus.req0_valid || bus.req1_valid;
    sel_id    = REQ0;
    if (bus.req0_valid && bus.req1_valid) begin
      sel_id = ~last_grant_q;
    end else if (bus.req1_valid) begin
      sel_id = REQ1;
    end
  end

  // No ready is offered while reset is asserted.
  assign bus.req0_ready = !reset && slot_free && sel_valid && (sel_id == REQ0);
  assign bus.req1_ready = !reset && slot_free && sel_valid && (sel_id == REQ1);
  assign handshake      = bus.req0_ready || bus.req1_ready;

  always_comb begin
    if (sel_id == REQ1) begin
      mux_op    = bus.req1_op;
      mux_data  = bus.req1_data;
      mux_shamt = bus.req1_shamt;
    end else begin
      mux_op    = bus.req0_op;
      mux_data  = bus.req0_data;
      mux_shamt = bus.req0_shamt;
    end
  end

  shift_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shift_core (
    .op_i     (mux_op),
    .data_i   (mux_data),
    .shamt_i  (mux_shamt),
    .result_o (shift_result)
  );

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    last_grant_d = last_grant_q;
    if (resp_valid_q && bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
    if (handshake) begin
      resp_valid_d = 1'b1;
      resp_id_d    = sel_id;
      resp_data_d  = shift_result;
      last_grant_d = sel_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= REQ0;
      resp_data_q  <= '0;
      last_grant_q <= REQ1;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  shift_arbiter_if bus ();

  shift_arbiter #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic        op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  // Reference model state
  logic        m_last;
  logic        m_rv;
  logic        m_rid;
  logic [31:0] m_rdata;

  logic        rv [2];
  logic        rop [2];
  logic [31:0] rd [2];
  logic [4:0]  rs [2];
  logic        pend [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] d, input logic [4:0] s);
    if (op) return $unsigned($signed(d) >>> s);
    return d << s;
  endfunction

  task automatic set_req(input logic id, input logic v, input logic op,
                         input logic [31:0] d, input logic [4:0] s);
    if (id == 1'b0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_data = d; bus.req0_shamt = s;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_data = d; bus.req1_shamt = s;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 5'd0);
    bus.resp_ready = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 5'd0);
    bus.resp_ready = 1'b1;

    vecs[0] = '{1'b0, 1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[2] = '{1'b0, 1'b1, 32'h7FFF_FFF0, 5'd0,  32'h7FFF_FFF0};
    vecs[3] = '{1'b1, 1'b0, 32'hF0F0_F0F0, 5'd4,  32'h0F0F_0F00};
    vecs[4] = '{1'b0, 1'b1, 32'hF000_0000, 5'd4,  32'hFF00_0000};
    vecs[5] = '{1'b1, 1'b1, 32'h4000_0000, 5'd30, 32'h0000_0001};
    vecs[6] = '{1'b0, 1'b0, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000};
    vecs[8] = '{1'b0, 1'b1, 32'h8765_4321, 5'd8,  32'hFF87_6543};
    vecs[9] = '{1'b1, 1'b0, 32'hA5A5_A5A5, 5'd1,  32'h4B4B_4B4A};

    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset state
    settle();
    chk("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("reset_resp_id",    {31'b0, bus.resp_id},    32'd0);
    chk("reset_resp_data",  bus.resp_data,           32'd0);
    chk("reset_ready0_idle", {31'b0, bus.req0_ready}, 32'd0);
    next_cycle();

    // Table-driven single shifts
    for (int i = 0; i < 10; i++) begin
      set_req(vecs[i].id, 1'b1, vecs[i].op, vecs[i].data, vecs[i].shamt);
      bus.resp_ready = 1'b1;
      settle();
      chk($sformatf("vec%0d_ready", i),
          {31'b0, (vecs[i].id ? bus.req1_ready : bus.req0_ready)}, 32'd1);
      chk($sformatf("vec%0d_other_ready", i),
          {31'b0, (vecs[i].id ? bus.req0_ready : bus.req1_ready)}, 32'd0);
      next_cycle();
      set_req(vecs[i].id, 1'b0, 1'b0, 32'h0, 5'd0);
      settle();
      chk($sformatf("vec%0d_resp_valid", i), {31'b0, bus.resp_valid}, 32'd1);
      chk($sformatf("vec%0d_resp_id", i),    {31'b0, bus.resp_id},    {31'b0, vecs[i].id});
      chk($sformatf("vec%0d_resp_data", i),  bus.resp_data,           vecs[i].exp);
      next_cycle();
    end
    settle();
    chk("drain_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    next_cycle();

    // Contention after reset: grants 0,1,0,1
    do_reset();
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_0001, 5'd4);
    set_req(1'b1, 1'b1, 1'b1, 32'h8000_0000, 5'd4);
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      if (k < 4) begin
        chk($sformatf("cont%0d_ready0", k), {31'b0, bus.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("cont%0d_ready1", k), {31'b0, bus.req1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      end
      if (k > 0) begin
        chk($sformatf("cont%0d_resp_valid", k), {31'b0, bus.resp_valid}, 32'd1);
        chk($sformatf("cont%0d_resp_id", k), {31'b0, bus.resp_id}, ((k - 1) % 2 == 0) ? 32'd0 : 32'd1);
        chk($sformatf("cont%0d_resp_data", k), bus.resp_data,
            ((k - 1) % 2 == 0) ? 32'h0000_0010 : 32'hF800_0000);
      end
      if (k == 4) bus.resp_ready = 1'b0;
      if (k < 4) next_cycle();
    end
    // Now in cycle after 4th grant with resp_ready=0: backpressure for 3 cycles.
    // The last grant in the loop went to 0 at k=4? No: ready was evaluated
    // with resp_ready=1 at k=4 before it dropped, so re-settle on this cycle.
    #1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("bp%0d_ready0", k), {31'b0, bus.req0_ready}, 32'd0);
      chk($sformatf("bp%0d_ready1", k), {31'b0, bus.req1_ready}, 32'd0);
      chk($sformatf("bp%0d_resp_valid", k), {31'b0, bus.resp_valid}, 32'd1);
      chk($sformatf("bp%0d_resp_id", k), {31'b0, bus.resp_id}, 32'd1);
      chk($sformatf("bp%0d_resp_data", k), bus.resp_data, 32'hF800_0000);
      next_cycle();
    end
    bus.resp_ready = 1'b1;
    settle();
    chk("bp_release_ready0", {31'b0, bus.req0_ready}, 32'd1);
    chk("bp_release_ready1", {31'b0, bus.req1_ready}, 32'd0);
    next_cycle();
    settle();
    chk("bp_release_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
    chk("bp_release_resp_id", {31'b0, bus.resp_id}, 32'd0);
    chk("bp_release_resp_data", bus.resp_data, 32'h0000_0010);

    // Reset mid-stream with last grant = 0 and a result held
    bus.resp_ready = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 5'd0);
    next_cycle();
    rst = 1'b1;
    set_req(1'b1, 1'b1, 1'b1, 32'h8000_0000, 5'd4);
    bus.resp_ready = 1'b1;
    settle();
    chk("rst_mid_ready0", {31'b0, bus.req0_ready}, 32'd0);
    chk("rst_mid_ready1", {31'b0, bus.req1_ready}, 32'd0);
    next_cycle();
    rst = 1'b0;
    settle();
    chk("rst_after_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_after_resp_data", bus.resp_data, 32'd0);
    chk("rst_after_ready0", {31'b0, bus.req0_ready}, 32'd1);
    chk("rst_after_ready1", {31'b0, bus.req1_ready}, 32'd0);
    next_cycle();

    // Randomized phase against the reference model
    do_reset();
    m_last = 1'b1; m_rv = 1'b0; m_rid = 1'b0; m_rdata = 32'h0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic want0, want1, winner, slot, hs0, hs1;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          rv[r]  = ($urandom_range(0, 9) < 7);
          rop[r] = $urandom_range(0, 1) == 1;
          rd[r]  = $urandom;
          rs[r]  = 5'($urandom_range(0, 31));
        end
        set_req(r[0], rv[r], rop[r], rd[r], rs[r]);
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      settle();

      want0  = rv[0];
      want1  = rv[1];
      winner = (want0 && want1) ? !m_last : want1;
      slot   = !m_rv || bus.resp_ready;
      hs0    = slot && want0 && (winner == 1'b0);
      hs1    = slot && want1 && (winner == 1'b1);

      chk($sformatf("rnd%0d_ready0", c), {31'b0, bus.req0_ready}, {31'b0, hs0});
      chk($sformatf("rnd%0d_ready1", c), {31'b0, bus.req1_ready}, {31'b0, hs1});
      chk($sformatf("rnd%0d_resp_valid", c), {31'b0, bus.resp_valid}, {31'b0, m_rv});
      if (m_rv) begin
        chk($sformatf("rnd%0d_resp_id", c), {31'b0, bus.resp_id}, {31'b0, m_rid});
        chk($sformatf("rnd%0d_resp_data", c), bus.resp_data, m_rdata);
      end

      if (m_rv && bus.resp_ready) m_rv = 1'b0;
      if (hs0 || hs1) begin
        m_rv    = 1'b1;
        m_rid   = hs1;
        m_rdata = ref_shift(rop[hs1], rd[hs1], rs[hs1]);
        m_last  = hs1;
      end
      pend[0] = rv[0] && !hs0;
      pend[1] = rv[1] && !hs1;
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
